aemb_dwb_resp: RTL and testbench
================================

AEMB_DWB_RESP -- requirements
Module: aemb_dwb_resp

Interface
REQ-001 The block SHALL have parameter AW, default 10, giving the word-address width (local memory of 2^AW 32-bit words).
REQ-002 The block SHALL have parameter WAIT, default 0, range 0..15, giving the wait states inserted before acknowledge.
REQ-003 The block SHALL have port nclk, input, 1 bit: the single clock; all state SHALL update on its falling edge.
REQ-004 The block SHALL have port nrst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port dwb_adr_i, input, 32 bits: byte address from the data-bus master.
REQ-006 The block SHALL have port dwb_dat_i, input, 32 bits: write data from the master.
REQ-007 The block SHALL have port dwb_dat_o, output, 32 bits: read data to the master.
REQ-008 The block SHALL have port dwb_sel_i, input, 4 bits: byte lane enables.
REQ-009 The block SHALL have port dwb_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-010 The block SHALL have port dwb_stb_i, input, 1 bit: transfer request.
REQ-011 The block SHALL have port dwb_ack_o, output, 1 bit: transfer acknowledge.
REQ-012 The block SHALL have port dwb_err_o, output, 1 bit: error response, present only when AEMB_DWB_ERR_EN is defined.

Function
REQ-013 The word index SHALL be dwb_adr_i[AW+1:2]; dwb_adr_i[1:0] SHALL be ignored.
REQ-014 Byte lanes SHALL be big-endian: sel[3] maps to [31:24], sel[2] to [23:16], sel[1] to [15:8], and sel[0] to [7:0].
REQ-015 The FSM SHALL have the states IDLE, WAIT and ACK.
REQ-016 In IDLE with stb=1: if WAIT==0, go to ACK; otherwise load the counter with WAIT and go to WAIT.
REQ-017 In WAIT: decrement the counter; when the counter equals 1 and stb=1, go to ACK.
REQ-018 In WAIT with stb=0: return to IDLE, commit no write, and raise no ack.
REQ-019 On the edge entering ACK, the block SHALL sample adr/we/sel/dat_i, perform the write (only the enabled lanes), or register the read word into dwb_dat_o.
REQ-020 In ACK, dwb_ack_o SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE unconditionally.
REQ-021 Latency from stb rising to ack high SHALL be WAIT+1 cycles; maximum throughput SHALL be one transfer every WAIT+2 cycles.
REQ-022 dwb_dat_o SHALL be 0 whenever ack is 0, and it SHALL hold the read word during the ack cycle; for writes it SHALL be 0.
REQ-023 The master SHALL drop stb in the ack cycle; if stb is still high in the following IDLE cycle, that is a new transfer.
REQ-024 A read with sel=0000 SHALL still acknowledge and return the full word; a write with sel=0000 SHALL acknowledge and modify nothing.
REQ-025 Changes on adr/dat_i/sel/we during WAIT SHALL be ignored until the sampling edge of REQ-019.

Reset
REQ-026 While nrst=0, the FSM SHALL be IDLE, the counter 0, dwb_ack_o 0, dwb_dat_o 0 and dwb_err_o 0, with no memory write.
REQ-027 A reset during WAIT SHALL abort the transfer with no write committed; memory contents SHALL NOT be cleared by reset.
REQ-028 The first transfer SHALL be accepted on the first falling edge after nrst deasserts.

Configuration
REQ-029 Macro AEMB_DWB_ERR_EN defined: an address with any of dwb_adr_i[31:AW+2] nonzero SHALL skip the write, keep dat_o=0, and pulse dwb_err_o (instead of ack) for one cycle with the same latency.
REQ-030 Macro AEMB_DWB_ERR_EN undefined: the dwb_err_o port SHALL be absent, upper address bits SHALL be ignored (aliasing), and every transfer SHALL receive an ack.

Verification
REQ-031 WAIT=0: write 0xDEADBEEF to adr 0x00000010 with sel=1111, then read adr 0x10 -> ack one cycle after each stb, read data 0xDEADBEEF.
REQ-032 Write 0x11223344 with sel=1111, then write 0xAABBCCDD with sel=0101, then read -> 0x11BB33DD.
REQ-033 WAIT=3: read -> ack exactly 4 cycles after stb rise; dropping stb after 2 cycles -> no ack, memory unchanged.
REQ-034 Reset mid-WAIT of a write of 0x12345678 to a word holding 0 -> ack never asserted, and a later read returns 0.
REQ-035 AEMB_DWB_ERR_EN, AW=10: write to 0x00001000 -> err pulse, no ack, word 0 unchanged; without the macro, the same write aliases to word 0 and acks.
REQ-036 Back-to-back reads of words 0..3 with stb held through the IDLE cycle -> four acks spaced WAIT+2 cycles, each with correct data and dat_o=0 between acks.

Source files
------------

// File: rtl/aemb_dwb_resp.sv
// Local data-bus responder: 2^AW x 32-bit word memory with big-endian byte lanes and WAIT wait states.
// Define AEMB_DWB_ERR_EN to add dwb_err_o and reject addresses with upper bits set.
module aemb_dwb_resp #(
  parameter int AW   = 10,
  parameter int WAIT = 0
) (
  input  logic        nclk,
  input  logic        nrst,
  input  logic [31:0] dwb_adr_i,
  input  logic [31:0] dwb_dat_i,
  output logic [31:0] dwb_dat_o,
  input  logic [3:0]  dwb_sel_i,
  input  logic        dwb_we_i,
  input  logic        dwb_stb_i,
  output logic        dwb_ack_o
`ifdef AEMB_DWB_ERR_EN
  ,
  output logic        dwb_err_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t        state;
  logic [3:0]    waitCnt;
  logic [AW-1:0] wordIdx;
  logic [31:0]   rdWord;
  logic          rdValid;
  logic          addrBad;
  logic          sample;
  logic          doWrite;
  logic          unusedAdr;

  assign wordIdx   = dwb_adr_i[AW+1:2];
  assign unusedAdr = ^{dwb_adr_i[1:0], dwb_adr_i[31:AW+2]};

`ifdef AEMB_DWB_ERR_EN
  assign addrBad = |dwb_adr_i[31:AW+2];
`else
  assign addrBad = 1'b0;
`endif

  // The edge that enters ACK is the only one that samples the bus and touches memory.
  assign sample  = nrst && dwb_stb_i &&
                   (((state == S_IDLE) && (WAIT == 0)) ||
                    ((state == S_WAIT) && (waitCnt == 4'd1)));
  assign doWrite = sample && dwb_we_i && !addrBad;

  // One byte-wide RAM per lane keeps partial writes a plain per-lane write enable.
  for (genvar gi = 0; gi < 4; gi++) begin : gLane
    logic [7:0] laneMem [2**AW];
    logic [7:0] laneRd;

    always_ff @(negedge nclk) begin
      if (doWrite && dwb_sel_i[gi])
        laneMem[wordIdx] <= dwb_dat_i[8*gi +: 8];
      if (sample)
        laneRd <= laneMem[wordIdx];
    end

    assign rdWord[8*gi +: 8] = laneRd;
  end

  always_ff @(negedge nclk or negedge nrst) begin
    if (!nrst) begin
      state     <= S_IDLE;
      waitCnt   <= 4'd0;
      dwb_ack_o <= 1'b0;
      rdValid   <= 1'b0;
`ifdef AEMB_DWB_ERR_EN
      dwb_err_o <= 1'b0;
`endif
    end else begin
      dwb_ack_o <= 1'b0;
      rdValid   <= 1'b0;
`ifdef AEMB_DWB_ERR_EN
      dwb_err_o <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (dwb_stb_i) begin
            if (WAIT == 0) begin
              state <= S_ACK;
            end else begin
              waitCnt <= 4'(WAIT);
              state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!dwb_stb_i) begin
            waitCnt <= 4'd0;
            state   <= S_IDLE;
          end else begin
            waitCnt <= waitCnt - 4'd1;
            if (waitCnt == 4'd1)
              state <= S_ACK;
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (sample) begin
        dwb_ack_o <= !addrBad;
        rdValid   <= !dwb_we_i && !addrBad;
`ifdef AEMB_DWB_ERR_EN
        dwb_err_o <= addrBad;
`endif
      end
    end
  end

  // Read data is only visible while a read is being acknowledged.
  assign dwb_dat_o = rdValid ? rdWord : 32'd0;

endmodule

// File: tb/tb_aemb_dwb_resp.sv
// Scoreboard bench for aemb_dwb_resp: one instance with WAIT=0 and one with WAIT=3.
// Expected responses (data, kind, arrival cycle) are queued by stimulus and checked by a monitor.
module tb_aemb_dwb_resp;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        isErr;
  } expItem;

`ifdef AEMB_DWB_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        nclk;
  logic        nrst;
  logic [31:0] adr  [2];
  logic [31:0] dat  [2];
  logic [31:0] datO [2];
  logic [3:0]  sel  [2];
  logic        we   [2];
  logic        stb  [2];
  logic        ack  [2];
  logic        err  [2];

  expItem sbq [2][$];
  expItem monE;
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  int     waitOf [2] = '{0, 3};

  aemb_dwb_resp #(.AW(10), .WAIT(0)) u0 (
    .nclk(nclk), .nrst(nrst),
    .dwb_adr_i(adr[0]), .dwb_dat_i(dat[0]), .dwb_dat_o(datO[0]),
    .dwb_sel_i(sel[0]), .dwb_we_i(we[0]), .dwb_stb_i(stb[0]),
    .dwb_ack_o(ack[0])
`ifdef AEMB_DWB_ERR_EN
    , .dwb_err_o(err[0])
`endif
  );

  aemb_dwb_resp #(.AW(10), .WAIT(3)) u3 (
    .nclk(nclk), .nrst(nrst),
    .dwb_adr_i(adr[1]), .dwb_dat_i(dat[1]), .dwb_dat_o(datO[1]),
    .dwb_sel_i(sel[1]), .dwb_we_i(we[1]), .dwb_stb_i(stb[1]),
    .dwb_ack_o(ack[1])
`ifdef AEMB_DWB_ERR_EN
    , .dwb_err_o(err[1])
`endif
  );

`ifndef AEMB_DWB_ERR_EN
  assign err[0] = 1'b0;
  assign err[1] = 1'b0;
`endif

  initial nclk = 1'b1;
  always #5 nclk = ~nclk;

  always @(negedge nclk) cyc <= cyc + 1;

  // Monitor: samples on the rising edge, away from the active falling edge.
  always @(posedge nclk) begin
    for (int i = 0; i < 2; i++) begin
      if (ack[i] || err[i]) begin
        checks++;
        if (sbq[i].size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp dut%0d: got ack=%0b err=%0b dat=%h at cyc %0d, expected no response",
                   i, ack[i], err[i], datO[i], cyc);
        end else begin
          monE = sbq[i].pop_front();
          if (ack[i] !== !monE.isErr || err[i] !== monE.isErr || datO[i] !== monE.data || cyc != monE.cyc) begin
            errors++;
            $display("FAIL resp dut%0d: got ack=%0b err=%0b dat=%h cyc=%0d, expected err=%0b dat=%h cyc=%0d",
                     i, ack[i], err[i], datO[i], cyc, monE.isErr, monE.data, monE.cyc);
          end
        end
      end else if (datO[i] !== 32'd0) begin
        checks++;
        errors++;
        $display("FAIL idle_dat dut%0d: got dat=%h at cyc %0d, expected 0", i, datO[i], cyc);
      end
    end
  end

  task automatic waitResp(input int i, input string name);
    int n = 0;
    do begin
      @(posedge nclk);
      n++;
    end while (!(ack[i] || err[i]) && n < 40);
    if (!(ack[i] || err[i])) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s dut%0d: got no response in 40 cycles, expected one", name, i);
    end
  endtask

  // Single transfer; called at rising edge + 1, returns likewise with the DUT back in IDLE.
  task automatic xfer(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic isErr, input logic [31:0] expD);
    expItem e;
    e.cyc = cyc + 1 + waitOf[i];
    e.data = expD;
    e.isErr = isErr;
    sbq[i].push_back(e);
    adr[i] = a; dat[i] = d; sel[i] = s; we[i] = w; stb[i] = 1'b1;
    waitResp(i, "xfer");
    #1;
    stb[i] = 1'b0; we[i] = 1'b0;
    @(posedge nclk); #1;
  endtask

  // Reads words 0..3 with stb held through each IDLE cycle.
  task automatic burst(input int i, input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] w3);
    expItem e;
    logic [31:0] words [4];
    words = '{w0, w1, w2, w3};
    for (int k = 0; k < 4; k++) begin
      e.cyc = cyc + 1 + waitOf[i] + k * (waitOf[i] + 2);
      e.data = words[k];
      e.isErr = 1'b0;
      sbq[i].push_back(e);
    end
    adr[i] = 32'h0; sel[i] = 4'hF; we[i] = 1'b0; stb[i] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      waitResp(i, "burst");
      #1;
      adr[i] = 32'((k + 1) * 4);
    end
    stb[i] = 1'b0;
    @(posedge nclk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      adr[i] = 32'h0; dat[i] = 32'h0; sel[i] = 4'h0; we[i] = 1'b0; stb[i] = 1'b0;
    end
    repeat (3) @(posedge nclk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ack[i] !== 1'b0 || err[i] !== 1'b0 || datO[i] !== 32'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got ack=%0b err=%0b dat=%h, expected 0 0 0",
                 i, ack[i], err[i], datO[i]);
      end
    end
    #1;
    nrst = 1'b1;

    // WAIT=0: first transfer accepted on the first falling edge after reset release.
    xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0);
    xfer(0, 0, 32'h10, 32'h0,        4'hF, 0, 32'hDEADBEEF);
    xfer(0, 0, 32'h13, 32'h0,        4'h0, 0, 32'hDEADBEEF);
    xfer(0, 1, 32'h20, 32'h11223344, 4'hF, 0, 32'h0);
    xfer(0, 1, 32'h20, 32'hAABBCCDD, 4'h5, 0, 32'h0);
    xfer(0, 0, 32'h20, 32'h0,        4'hF, 0, 32'h11BB33DD);
    xfer(0, 1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, 32'h0);
    xfer(0, 0, 32'h20, 32'h0,        4'hF, 0, 32'h11BB33DD);
    xfer(0, 1, 32'h24, 32'h00000000, 4'hF, 0, 32'h0);
    xfer(0, 1, 32'h24, 32'h0000FF00, 4'h2, 0, 32'h0);
    xfer(0, 0, 32'h24, 32'h0,        4'hF, 0, 32'h0000FF00);
    for (int k = 0; k < 4; k++)
      xfer(0, 1, 32'(k * 4), 32'h0A0B0C00 | 32'(k), 4'hF, 0, 32'h0);
    // Upper address bits: alias onto word 0, or error response with the word untouched.
    xfer(0, 1, 32'h1000, 32'hA5A5A5A5, 4'hF, ERR_EN, 32'h0);
    xfer(0, 0, 32'h0, 32'h0, 4'hF, 0, ERR_EN ? 32'h0A0B0C00 : 32'hA5A5A5A5);
    burst(0, ERR_EN ? 32'h0A0B0C00 : 32'hA5A5A5A5, 32'h0A0B0C01, 32'h0A0B0C02, 32'h0A0B0C03);

    // WAIT=3: latency, aborted transfer, reset during WAIT, burst spacing.
    xfer(1, 1, 32'h14, 32'hCAFEF00D, 4'hF, 0, 32'h0);
    xfer(1, 0, 32'h14, 32'h0,        4'hF, 0, 32'hCAFEF00D);
    adr[1] = 32'h14; dat[1] = 32'hFFFFFFFF; sel[1] = 4'hF; we[1] = 1'b1; stb[1] = 1'b1;
    repeat (2) @(posedge nclk);
    #1; stb[1] = 1'b0; we[1] = 1'b0;
    repeat (8) @(posedge nclk);
    #1;
    xfer(1, 0, 32'h14, 32'h0, 4'hF, 0, 32'hCAFEF00D);

    xfer(1, 1, 32'h1C, 32'h0, 4'hF, 0, 32'h0);
    adr[1] = 32'h1C; dat[1] = 32'h12345678; sel[1] = 4'hF; we[1] = 1'b1; stb[1] = 1'b1;
    repeat (2) @(posedge nclk);
    #1; nrst = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    repeat (2) @(posedge nclk);
    #1; nrst = 1'b1;
    repeat (6) @(posedge nclk);
    #1;
    xfer(1, 0, 32'h1C, 32'h0, 4'hF, 0, 32'h0);

    for (int k = 0; k < 4; k++)
      xfer(1, 1, 32'(k * 4), 32'h50600000 + 32'(k * 17), 4'hF, 0, 32'h0);
    burst(1, 32'h50600000, 32'h50600011, 32'h50600022, 32'h50600033);

    repeat (10) @(posedge nclk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (sbq[i].size() != 0) begin
        errors++;
        $display("FAIL pending_resp dut%0d: got %0d responses still outstanding, expected 0", i, sbq[i].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
